// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage (master) and the sequential divider (slave).
// Latency: none; wires only.
// Backpressure: the master holds start_i high until ready_o, then drops it.
interface div_seq_if #(
    parameter int DATA_W = 32
);
    logic                signed_i;
    logic [DATA_W-1:0]   opdata1_i;
    logic [DATA_W-1:0]   opdata2_i;
    logic                start_i;
    logic                annul_i;
    logic [2*DATA_W-1:0] result_o;
    logic                ready_o;

    modport master (
        output signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU returning {remainder, quotient}; DIV_ANNUL_EN enables annul_i.
// Latency: ready_o 33 cycles after the IDLE cycle that samples start_i (2 cycles for a zero divisor).
// Backpressure: result and ready_o held in END while start_i stays high; start_i low returns to IDLE.
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic     cpu_clk,
    input  logic     cpu_rst_n,
    div_seq_if.slave div_if
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic annul;
`ifdef DIV_ANNUL_EN
    assign annul = div_if.annul_i;
`else
    logic annul_unused;
    assign annul_unused = div_if.annul_i;
    assign annul        = 1'b0;
`endif

    // Operand magnitudes; the most negative value maps onto itself, which is
    // still the correct unsigned magnitude.
    logic              op1_neg, op2_neg;
    logic [DATA_W-1:0] op1_mag, op2_mag;

    always_comb begin
        op1_neg = div_if.signed_i & div_if.opdata1_i[DATA_W-1];
        op2_neg = div_if.signed_i & div_if.opdata2_i[DATA_W-1];
        op1_mag = op1_neg ? -div_if.opdata1_i : div_if.opdata1_i;
        op2_mag = op2_neg ? -div_if.opdata2_i : div_if.opdata2_i;
    end

    // One restoring step over the (DATA_W+1)-bit working remainder.
    logic [DATA_W:0]   rem_s, diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_nxt, quot_nxt, rem_fix, quot_fix;

    always_comb begin
        rem_s    = {rem_q, dvd_q[DATA_W-1]};
        diff     = rem_s - {1'b0, dvs_q};
        q_bit    = ~diff[DATA_W];
        rem_nxt  = q_bit ? diff[DATA_W-1:0] : rem_s[DATA_W-1:0];
        quot_nxt = {quot_q[DATA_W-2:0], q_bit};
        quot_fix = neg_quot_q ? -quot_nxt : quot_nxt;
        rem_fix  = neg_rem_q  ? -rem_nxt  : rem_nxt;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (div_if.start_i && !annul) begin
                    if (div_if.opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
                        dvd_d      = op1_mag;
                        dvs_d      = op2_mag;
                        rem_d      = '0;
                        quot_d     = '0;
                        cnt_d      = '0;
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                        state_d    = S_ON;
                    end
                end
            end

            S_DIVZERO: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end

            S_ON: begin
                if (annul) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    dvd_d  = dvd_q << 1;
                    rem_d  = rem_nxt;
                    quot_d = quot_nxt;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_d = {rem_fix, quot_fix};
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end
                end
            end

            S_END: begin
                if (!div_if.start_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                ready_d  = 1'b0;
                result_d = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign div_if.result_o = result_q;
    assign div_if.ready_o  = ready_q;
endmodule
